// File: rtl/mdu_ctrl_if.sv
// Execute-stage <-> multiply/divide controller request and HI/LO result bundle.
// Request side: start/op/opa/opb/flush.
// Response side: stall_req/busy/hilo_we/hi_wdata/lo_wdata.
// Ports (master = execute stage, slave = mdu_ctrl):
//   start, op[1:0], opa, opb, flush        : master -> slave
//   stall_req, busy, hilo_we, hi/lo_wdata  : slave -> master
interface mdu_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              flush;
  logic              stall_req;
  logic              busy;
  logic              hilo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;

  modport master (
    output start, op, opa, opb, flush,
    input  stall_req, busy, hilo_we, hi_wdata, lo_wdata
  );

  modport slave (
    input  start, op, opa, opb, flush,
    output stall_req, busy, hilo_we, hi_wdata, lo_wdata
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer writing the HI/LO pair.
// Latency: request cycle 0, single hilo_we strobe in cycle DATA_W+1.
// Backpressure: stall_req holds the pipeline for cycles 0..DATA_W; flush aborts at any time.
// Ports:
//   cpu_clk_50M : rising-edge clock
//   cpu_rst_n   : asynchronous active-low reset
//   bus         : slave side of mdu_ctrl_if (request in, stall/busy/HI-LO write out)
module mdu_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst_n,
  mdu_ctrl_if.slave  bus
);
  localparam int              CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  // Multiply: {partial product high, multiplier/product low}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*DATA_W-1:0] acc, acc_nxt;
  // Multiplicand for multiply, divisor for divide (both magnitudes).
  logic [DATA_W-1:0]   opnd, opnd_nxt;
  logic                sign_a, sign_a_nxt;
  logic                sign_b, sign_b_nxt;
  logic [1:0]          op_q, op_q_nxt;
  logic [DATA_W-1:0]   hold_hi, hold_lo;
  logic                stall;

  // ---------------- request decode ----------------
  logic              req_signed, req_div0, req_ok;
  logic [DATA_W-1:0] abs_a, abs_b;

  assign req_signed = ~bus.op[0];
  assign req_div0   = bus.op[1] && (bus.opb == '0);
  assign req_ok     = bus.start && !bus.flush && !req_div0;
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  assign abs_a = (req_signed && bus.opa[DATA_W-1]) ? -bus.opa : bus.opa;
  assign abs_b = (req_signed && bus.opb[DATA_W-1]) ? -bus.opb : bus.opb;

  // ---------------- one iteration ----------------
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] mul_step, div_step;

  // Shift-add: add multiplicand into the upper half when the multiplier LSB
  // is set, then shift the whole accumulator (with carry) right by one.
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[DATA_W-1:1]};

  // Restoring divide: bring the next dividend bit into the remainder, try a
  // subtract, keep it only when it does not borrow.
  assign div_shift = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_step  = div_diff[DATA_W] ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                      : {div_diff[DATA_W-1:0],  acc[DATA_W-2:0], 1'b1};

  // ---------------- sign correction ----------------
  logic                op_signed, neg_res;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   fix_hi, fix_lo;

  assign op_signed = ~op_q[0];
  assign neg_res   = op_signed && (sign_a ^ sign_b);
  assign prod_fix  = neg_res ? -acc : acc;

  always_comb begin
    fix_hi = prod_fix[2*DATA_W-1:DATA_W];
    fix_lo = prod_fix[DATA_W-1:0];
    if (op_q[1]) begin
      // Quotient sign follows sign_a^sign_b, remainder follows the dividend.
      fix_lo = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
      fix_hi = (op_signed && sign_a) ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    end
  end

  // ---------------- FSM next state ----------------
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc;
    opnd_nxt   = opnd;
    sign_a_nxt = sign_a;
    sign_b_nxt = sign_b;
    op_q_nxt   = op_q;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        // The request cycle itself stalls; divide-by-zero is dropped silently.
        stall = req_ok;
        if (req_ok) begin
          state_nxt  = RUN;
          cnt_nxt    = '0;
          op_q_nxt   = bus.op;
          sign_a_nxt = req_signed & bus.opa[DATA_W-1];
          sign_b_nxt = req_signed & bus.opb[DATA_W-1];
          acc_nxt    = {{DATA_W{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
          opnd_nxt   = bus.op[1] ? abs_b : abs_a;
        end
      end
      RUN: begin
        stall   = 1'b1;
        acc_nxt = op_q[1] ? div_step : mul_step;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = FIX;
          cnt_nxt   = '0;
        end
      end
      FIX: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Flush wins over a new request and over FIX completion.
    if (bus.flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      op_q   <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc    <= acc_nxt;
      opnd   <= opnd_nxt;
      sign_a <= sign_a_nxt;
      sign_b <= sign_b_nxt;
      op_q   <= op_q_nxt;
    end
  end

  // Result ports show the last written HI/LO outside the write cycle.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      hold_hi <= '0;
      hold_lo <= '0;
    end else if (bus.hilo_we) begin
      hold_hi <= fix_hi;
      hold_lo <= fix_lo;
    end
  end

  // ---------------- outputs ----------------
  // Gated by reset so a request held high during reset cannot raise stall.
  assign bus.stall_req = stall & cpu_rst_n;
  assign bus.busy      = (state != IDLE);
  assign bus.hilo_we   = (state == FIX) && !bus.flush;
  assign bus.hi_wdata  = bus.hilo_we ? fix_hi : hold_hi;
  assign bus.lo_wdata  = bus.hilo_we ? fix_lo : hold_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops vs an arithmetic model.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// Ports: drives the master side of mdu_ctrl_if; clock and reset are plain signals.
module tb_mdu_ctrl;
  localparam int DATA_W = 32;
  localparam int LAT    = DATA_W + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.DATA_W(DATA_W)) bus ();

  mdu_ctrl #(.DATA_W(DATA_W)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;
  // Architectural HI/LO as the model believes them to be.
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // Reference: plain arithmetic; returns {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      2'b00: r = sa * sb;
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      default: r = {a % b, a / b};
    endcase
    return r;
  endfunction

  // Issues one request and observes it; the request is withdrawn after the
  // first cycle with stall low. Returns after 'watch' cycles past that point.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int watch,
                        output logic [31:0] hi, output logic [31:0] lo, output int we_cycle,
                        output int we_count, output int stall_cnt, output int stall_first,
                        output int stall_last, output int busy_cnt);
    int done_at;
    done_at = -1;
    hi = '0; lo = '0; we_cycle = -1; we_count = 0;
    stall_cnt = 0; stall_first = -1; stall_last = -1; busy_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.opa = a; bus.opb = b; bus.flush = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.stall_req) begin
        stall_cnt++;
        if (stall_first < 0) stall_first = c;
        stall_last = c;
      end
      if (bus.busy) busy_cnt++;
      if (bus.hilo_we) begin
        we_count++;
        if (we_cycle < 0) begin
          we_cycle = c; hi = bus.hi_wdata; lo = bus.lo_wdata;
        end
      end
      if (!bus.stall_req && done_at < 0) done_at = c;
      if (done_at >= 0 && c >= done_at + watch) break;
      @(negedge clk);
      if (done_at >= 0) bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0; bus.flush = 1'b0;
    #12;
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_req); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.hilo_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.hilo_we); end
    checks++; if ({bus.hi_wdata, bus.lo_wdata} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h want 0", {bus.hi_wdata, bus.lo_wdata}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_divu_basic();
    logic [31:0] hi, lo;
    int wc, wn, sc, sf, sl, bc;
    run_op(2'b11, 32'd100, 32'd7, 6, hi, lo, wc, wn, sc, sf, sl, bc);
    checks++; if (wc !== LAT) begin errors++; $display("FAIL divu_latency: got %0d want %0d", wc, LAT); end
    checks++; if (wn !== 1) begin errors++; $display("FAIL divu_we_count: got %0d want 1", wn); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_result: got hi=%0d lo=%0d want hi=2 lo=14", hi, lo); end
    checks++; if (sc !== 33 || sf !== 0 || sl !== 32) begin errors++; $display("FAIL divu_stall: got cnt=%0d first=%0d last=%0d want 33/0/32", sc, sf, sl); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 33", bc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL divu_idle_after: busy=%b want 0", bus.busy); end
    checks++; if (bus.hi_wdata !== 32'd2 || bus.lo_wdata !== 32'd14) begin errors++; $display("FAIL divu_hold: got hi=%0d lo=%0d want 2/14", bus.hi_wdata, bus.lo_wdata); end
    m_hi = 32'd2; m_lo = 32'd14;
  endtask

  task automatic test_div_signed();
    logic [31:0] hi, lo;
    int wc, wn, sc, sf, sl, bc;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 3, hi, lo, wc, wn, sc, sf, sl, bc);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF || wc !== LAT) begin errors++; $display("FAIL div_signed: got hi=%h lo=%h cyc=%0d want ffffffff/fffffffd/%0d", hi, lo, wc, LAT); end
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    int wc, wn, sc, sf, sl, bc;
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, 3, hi, lo, wc, wn, sc, sf, sl, bc);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFE || wc !== LAT) begin errors++; $display("FAIL mult_signed: got hi=%h lo=%h cyc=%0d want ffffffff/fffffffe", hi, lo, wc); end
    run_op(2'b01, 32'hFFFFFFFF, 32'd2, 3, hi, lo, wc, wn, sc, sf, sl, bc);
    checks++; if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE || wc !== LAT) begin errors++; $display("FAIL multu: got hi=%h lo=%h cyc=%0d want 00000001/fffffffe", hi, lo, wc); end
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo;
    int wc, wn, sc, sf, sl, bc;
    run_op(2'b10, 32'd1234, 32'd0, 10, hi, lo, wc, wn, sc, sf, sl, bc);
    checks++; if (sc !== 0) begin errors++; $display("FAIL div0_stall: got %0d stall cycles want 0", sc); end
    checks++; if (wn !== 0 || bc !== 0) begin errors++; $display("FAIL div0_idle: got we=%0d busy=%0d want 0/0", wn, bc); end
    checks++; if (bus.hi_wdata !== m_hi || bus.lo_wdata !== m_lo) begin errors++; $display("FAIL div0_hold: got %h/%h want %h/%h", bus.hi_wdata, bus.lo_wdata, m_hi, m_lo); end
  endtask

  task automatic test_flush();
    logic [31:0] hi, lo;
    int wc, wn, sc, sf, sl, bc;
    int we_seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.opa = 32'd5000; bus.opb = 32'd3; bus.flush = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.hilo_we !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL flush_cycle: we=%b busy=%b want 0/1", bus.hilo_we, bus.busy); end
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0) begin errors++; $display("FAIL flush_idle: busy=%b stall=%b want 0/0", bus.busy, bus.stall_req); end
    we_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (bus.hilo_we) we_seen++;
    end
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL flush_no_write: got %0d writes want 0", we_seen); end
    run_op(2'b01, 32'd3, 32'd5, 3, hi, lo, wc, wn, sc, sf, sl, bc);
    checks++; if (hi !== 32'd0 || lo !== 32'd15 || wc !== LAT) begin errors++; $display("FAIL flush_then_multu: got hi=%0d lo=%0d cyc=%0d want 0/15/%0d", hi, lo, wc, LAT); end
    m_hi = hi; m_lo = lo;
  endtask

  // Flush arriving in the completion cycle suppresses the write.
  task automatic test_flush_fix();
    int we_seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.opa = 32'd7; bus.opb = 32'hFFFFFFFD; bus.flush = 1'b0;
    repeat (LAT) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.hilo_we !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL flush_fix_we: we=%b busy=%b want 0/1", bus.hilo_we, bus.busy); end
    checks++; if (bus.hi_wdata !== m_hi || bus.lo_wdata !== m_lo) begin errors++; $display("FAIL flush_fix_hold: got %h/%h want %h/%h", bus.hi_wdata, bus.lo_wdata, m_hi, m_lo); end
    @(negedge clk);
    bus.flush = 1'b0; bus.start = 1'b0;
    we_seen = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.hilo_we || bus.busy) we_seen++;
      @(negedge clk);
    end
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL flush_fix_after: got %0d active cycles want 0", we_seen); end
  endtask

  task automatic test_async_reset();
    int act;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.opa = 32'h12345; bus.opb = 32'hFFFF0001; bus.flush = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0; bus.start = 1'b0;
    #1;
    checks++; if (bus.stall_req !== 1'b0 || bus.busy !== 1'b0 || bus.hilo_we !== 1'b0) begin errors++; $display("FAIL async_reset_ctl: stall=%b busy=%b we=%b want 0", bus.stall_req, bus.busy, bus.hilo_we); end
    checks++; if ({bus.hi_wdata, bus.lo_wdata} !== 64'h0) begin errors++; $display("FAIL async_reset_hilo: got %h want 0", {bus.hi_wdata, bus.lo_wdata}); end
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.hilo_we || bus.busy) act++;
      @(negedge clk);
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL async_reset_after: got %0d active cycles want 0", act); end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_div_overflow();
    logic [31:0] hi, lo;
    int wc, wn, sc, sf, sl, bc;
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 3, hi, lo, wc, wn, sc, sf, sl, bc);
    checks++; if (lo !== 32'h80000000 || hi !== 32'h0 || wn !== 1) begin errors++; $display("FAIL div_overflow: got hi=%h lo=%h we=%0d want 0/80000000/1", hi, lo, wn); end
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_back_to_back();
    logic [31:0] hi, lo;
    logic [63:0] exp;
    int wc, wn, sc, sf, sl, bc;
    run_op(2'b01, 32'h12345678, 32'h9ABCDEF0, 0, hi, lo, wc, wn, sc, sf, sl, bc);
    exp = ref_result(2'b01, 32'h12345678, 32'h9ABCDEF0);
    checks++; if ({hi, lo} !== exp || wc !== LAT) begin errors++; $display("FAIL b2b_first: got %h cyc=%0d want %h cyc=%0d", {hi, lo}, wc, exp, LAT); end
    run_op(2'b11, 32'd1000, 32'd33, 4, hi, lo, wc, wn, sc, sf, sl, bc);
    exp = ref_result(2'b11, 32'd1000, 32'd33);
    checks++; if ({hi, lo} !== exp || wc !== LAT || sf !== 0) begin errors++; $display("FAIL b2b_second: got %h cyc=%0d stall0=%0d want %h cyc=%0d stall0=0", {hi, lo}, wc, sf, exp, LAT); end
    m_hi = hi; m_lo = lo;
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, hi, lo;
    logic [63:0] exp;
    int wc, wn, sc, sf, sl, bc, sel, watch;
    for (int i = 0; i < 30; i++) begin
      o   = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) begin a = a & 32'hFF; b = (b & 32'hF) + 32'd1; end
      watch = (i % 3 == 0 && i != 29) ? 0 : 2;
      run_op(o, a, b, watch, hi, lo, wc, wn, sc, sf, sl, bc);
      if (o[1] && b == 32'd0) begin
        checks++; if (wn !== 0 || sc !== 0) begin errors++; $display("FAIL rand_div0[%0d]: we=%0d stall=%0d want 0/0", i, wn, sc); end
        checks++; if (bus.hi_wdata !== m_hi || bus.lo_wdata !== m_lo) begin errors++; $display("FAIL rand_div0_hold[%0d]: got %h/%h want %h/%h", i, bus.hi_wdata, bus.lo_wdata, m_hi, m_lo); end
      end else begin
        exp = ref_result(o, a, b);
        checks++; if ({hi, lo} !== exp) begin errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, {hi, lo}, exp); end
        checks++; if (wc !== LAT || sc !== LAT) begin errors++; $display("FAIL rand_timing[%0d]: we_cycle=%0d stall=%0d want %0d/%0d", i, wc, sc, LAT, LAT); end
        m_hi = exp[63:32]; m_lo = exp[31:0];
      end
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_mult();
    test_div_zero();
    test_flush();
    test_flush_fix();
    test_async_reset();
    test_div_overflow();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide sequencing controller for the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU requests from the execute stage and runs a 32-iteration shift-add multiply or restoring divide.
- Holds the pipeline via stall_req until the result is ready, then drives a single combined HI/LO write strobe with the 64-bit result.
- Sits between the execute stage and the HI/LO register block; honours pipeline flush.

Parameters:
- DATA_W, 32, operand and HI/LO word width; the iteration count equals DATA_W.

Ports:
- cpu_clk_50M  input  1  system clock, rising edge
- cpu_rst_n  input  1  asynchronous active-low reset
- start  input  1  request valid; level, held high by the pipeline while stalled
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- opa  input  DATA_W  rs operand (multiplicand / dividend)
- opb  input  DATA_W  rt operand (multiplier / divisor)
- flush  input  1  abort current operation (exception/redirect)
- stall_req  output  1  hold pipeline while the operation is in progress
- busy  output  1  FSM not in IDLE
- hilo_we  output  1  one-cycle write strobe for both HI and LO
- hi_wdata  output  DATA_W  HI result (product high word / remainder)
- lo_wdata  output  DATA_W  LO result (product low word / quotient)

Behaviour:
- Reset (async, cpu_rst_n=0): state=IDLE, counter=0, all internal registers 0, stall_req=0, busy=0, hilo_we=0, hi_wdata=0, lo_wdata=0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1, flush=0, divisor nonzero or multiply op: latch |opa| and |opb| (signed ops) or raw values (unsigned ops), plus sign_a, sign_b and op; counter=0; go to RUN.
  - stall_req=start & ~flush combinationally in IDLE (the request cycle itself stalls).
- Divide by zero (op=DIV/DIVU with opb=0): remain in IDLE, stall_req=0, no HI/LO write. HI/LO retain their old values.
- RUN: one iteration per cycle; counter increments each cycle; at counter=DATA_W-1 go to FIX. stall_req=1.
  - Multiply: 2*DATA_W accumulator, shift-add on the multiplier LSB.
  - Divide: restoring divide; shift the partial remainder left, subtract the divisor if no borrow, shift in the quotient bit.
- FIX: apply sign correction, assert hilo_we=1 for exactly this cycle, drive hi_wdata/lo_wdata, stall_req=0 so the pipeline advances at this edge. Next state is IDLE.
- Latency: request at cycle 0 to hilo_we in cycle DATA_W+1, i.e. cycle 33 for DATA_W=32. Pipeline stalled for cycles 0..DATA_W.
- Sign rules:
  - MULT: 64-bit product negated if sign_a^sign_b.
  - DIV: quotient negated if sign_a^sign_b; remainder takes sign_a.
  - Unsigned ops: no correction.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no trap.
- hi_wdata/lo_wdata hold their last value outside FIX. Consumers qualify them with hilo_we only.
- flush=1 in any state: next edge goes to IDLE, counter=0, hilo_we=0 that edge. No HI/LO write for the aborted op. flush has priority over start and over FIX completion.
- start deasserted mid-RUN without flush: the operation continues to completion. Only flush aborts.
- Back-to-back requests: a new start is sampled only in IDLE, one cycle after FIX at the earliest.
- busy=1 in RUN and FIX.

Test Plan:
- DIVU opa=100, opb=7 -> stall_req high cycles 0..32; hilo_we pulse in cycle 33 with lo=14, hi=2; back to IDLE.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- MULT opa=0xFFFFFFFF, opb=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV opb=0 -> stall_req=0 in the request cycle, no hilo_we ever, FSM stays IDLE.
- flush at cycle 10 of a DIVU -> IDLE at next edge, no hilo_we. A following MULTU 3*5 gives hi=0, lo=15 at the normal latency.
- cpu_rst_n low at cycle 20 of a MULT -> all outputs 0 immediately (asynchronous), no write after release. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
